// File: rtl/komut_pkg.sv
// Shared opcode constants, field layout and bit positions for the instruction encoder.
package komut_pkg;

    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;

    localparam int OPC_LSB  = 0;
    localparam int RD_LSB   = 7;
    localparam int F3_LSB   = 12;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int F7_BIT   = 30;
    localparam int IMMI_LSB = 20;
    localparam int IMMU_LSB = 12;
    localparam int BLO_LSB  = 7;
    localparam int BHI_LSB  = 25;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [3:0]  aluop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } komut_alanlari_t;

endpackage

// File: rtl/komut_fifo.sv
// Word FIFO with a registered head word: a push into an empty FIFO is visible
// on the next cycle, and the head holds its last value once the FIFO drains.
module komut_fifo #(
    parameter int DERINLIK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [31:0]                   data_i,
    input  logic                          pop_i,
    output logic [31:0]                   data_o,
    output logic                          valid_o,
    output logic [$clog2(DERINLIK):0]     seviye_o
);

    localparam int AW = $clog2(DERINLIK);
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] DOLU = SW'(DERINLIK);

    logic [31:0]   mem_q [DERINLIK];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] seviye_q, seviye_d;
    logic [SW-1:0] kalan;
    logic [31:0]   bas_q, bas_d;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && (seviye_q != '0);
    assign push_ok = push_i && (seviye_q != DOLU);

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        kalan    = seviye_q - SW'(pop_ok);
        seviye_d = kalan + SW'(push_ok);
        bas_d    = bas_q;
        // When nothing older survives the pop, the incoming word becomes the head.
        if (kalan != '0) begin
            bas_d = mem_q[rd_ptr_d];
        end else if (push_ok) begin
            bas_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seviye_q <= '0;
            bas_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            seviye_q <= seviye_d;
            bas_q    <= bas_d;
        end
    end

    assign data_o   = bas_q;
    assign valid_o  = (seviye_q != '0);
    assign seviye_o = seviye_q;

endmodule

// File: rtl/komut_kodlayici.sv
// Packs R/I/U/B field tuples into 32-bit instruction words and queues them in a FIFO.
// Define KOMUT_HATA_SAYACI_EN to get a saturating count of rejected tuples on hata_sayisi.
module komut_kodlayici
    import komut_pkg::*;
#(
    parameter int DERINLIK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [6:0]                    opcode,
    input  logic [3:0]                    aluop,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    input  logic [4:0]                    rd,
    input  logic [31:0]                   imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   komut,
    output logic                          hata,
    output logic [$clog2(DERINLIK):0]     seviye,
    output logic [7:0]                    hata_sayisi
);

    localparam int SW = $clog2(DERINLIK) + 1;
    localparam logic [SW-1:0] DOLU = SW'(DERINLIK);

    komut_alanlari_t alan;
    logic [31:0]     kod;
    logic            gecerli;
    logic            kabul;
    logic            yaz;
    logic            hata_q;

    assign alan = '{opcode: opcode, aluop: aluop, rs1: rs1, rs2: rs2, rd: rd, imm: imm};

    always_comb begin
        kod     = '0;
        gecerli = 1'b0;
        kod[OPC_LSB +: 7] = alan.opcode;
        case (alan.opcode)
            OP_R: begin
                gecerli              = 1'b1;
                kod[RD_LSB +: 5]     = alan.rd;
                kod[F3_LSB +: 3]     = alan.aluop[2:0];
                kod[RS1_LSB +: 5]    = alan.rs1;
                kod[RS2_LSB +: 5]    = alan.rs2;
                kod[F7_BIT]          = alan.aluop[3];
            end
            OP_I: begin
                gecerli              = (alan.imm[31:12] == '0) && !alan.aluop[3];
                kod[RD_LSB +: 5]     = alan.rd;
                kod[F3_LSB +: 3]     = alan.aluop[2:0];
                kod[RS1_LSB +: 5]    = alan.rs1;
                kod[IMMI_LSB +: 12]  = alan.imm[11:0];
            end
            OP_U: begin
                gecerli              = (alan.imm[31:20] == '0);
                kod[RD_LSB +: 5]     = alan.rd;
                kod[IMMU_LSB +: 20]  = alan.imm[19:0];
            end
            OP_B: begin
                // Branch offsets are even and fit in 13 bits; bit 0 is never encoded.
                gecerli              = !alan.imm[0] && (alan.imm[31:13] == '0) && !alan.aluop[3];
                kod[F3_LSB +: 3]     = alan.aluop[2:0];
                kod[RS1_LSB +: 5]    = alan.rs1;
                kod[RS2_LSB +: 5]    = alan.rs2;
                kod[BLO_LSB +: 5]    = alan.imm[5:1];
                kod[BHI_LSB +: 7]    = alan.imm[12:6];
            end
            default: gecerli = 1'b0;
        endcase
    end

    // No push-through: a full FIFO refuses input even while it is being drained.
    assign in_ready = (seviye != DOLU);
    assign kabul    = in_valid && in_ready;
    assign yaz      = kabul && gecerli;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hata_q <= 1'b0;
        end else begin
            hata_q <= kabul && !gecerli;
        end
    end

    assign hata = hata_q;

`ifdef KOMUT_HATA_SAYACI_EN
    logic [7:0] sayac_q, sayac_d;

    always_comb begin
        sayac_d = sayac_q;
        if (kabul && !gecerli && (sayac_q != 8'hFF)) begin
            sayac_d = sayac_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayac_q <= '0;
        end else begin
            sayac_q <= sayac_d;
        end
    end

    assign hata_sayisi = sayac_q;
`else
    assign hata_sayisi = '0;
`endif

    komut_fifo #(
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (yaz),
        .data_i   (kod),
        .pop_i    (out_ready),
        .data_o   (komut),
        .valid_o  (out_valid),
        .seviye_o (seviye)
    );

endmodule

// File: tb/tb_komut_kodlayici.sv
// Randomized and directed bench for komut_kodlayici against a queue-based reference model.
module tb_komut_kodlayici;

    localparam int D  = 4;
    localparam int SW = $clog2(D) + 1;
`ifdef KOMUT_HATA_SAYACI_EN
    localparam bit SAYAC = 1'b1;
`else
    localparam bit SAYAC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    opcode = '0;
    logic [3:0]    aluop = '0;
    logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0]   imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   komut;
    logic          hata;
    logic [SW-1:0] seviye;
    logic [7:0]    hata_sayisi;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q_m[$];
    int          cnt_m = 0;
    logic [31:0] head_m = '0;
    bit          hata_m = 1'b0;

    komut_kodlayici #(.DERINLIK(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .aluop(aluop), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .komut(komut), .hata(hata),
        .seviye(seviye), .hata_sayisi(hata_sayisi)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Instruction layout written directly as field concatenations.
    function automatic bit ref_enc(input logic [6:0] op, input logic [3:0] alu,
                                   input logic [4:0] a, input logic [4:0] b,
                                   input logic [4:0] d, input logic [31:0] im,
                                   output logic [31:0] w);
        w = 32'h0;
        case (op)
            7'b0000001: begin w = {1'b0, alu[3], 5'b0, b, a, alu[2:0], d, op}; return 1'b1; end
            7'b0000011: begin w = {im[11:0], a, alu[2:0], d, op}; return (im < 32'd4096) && (alu < 4'd8); end
            7'b0000111: begin w = {im[19:0], d, op}; return im < 32'h0010_0000; end
            7'b0001111: begin
                w = {im[12:6], b, a, alu[2:0], im[5:1], op};
                return (im % 2 == 0) && (im < 32'd8192) && (alu < 4'd8);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick(output bit acc);
        bit pop, ok;
        logic [31:0] w;
        acc = in_valid && (q_m.size() != D);
        pop = out_ready && (q_m.size() != 0);
        ok  = ref_enc(opcode, aluop, rs1, rs2, rd, imm, w);
        @(posedge clk); #1;
        if (pop) void'(q_m.pop_front());
        if (acc && ok) q_m.push_back(w);
        hata_m = acc && !ok;
        if (hata_m && SAYAC && cnt_m < 255) cnt_m++;
        if (q_m.size() != 0) head_m = q_m[0];
        if (acc) $display("tx op=%b alu=%h imm=%h ok=%0d word=%h level=%0d", opcode, aluop, imm, ok, w, q_m.size());
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q_m.delete(); cnt_m = 0; head_m = '0; hata_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rand_tuple();
        int sel;
        sel = $urandom_range(0, 4);
        case (sel)
            0: opcode = 7'b0000001;
            1: opcode = 7'b0000011;
            2: opcode = 7'b0000111;
            3: opcode = 7'b0001111;
            default: opcode = 7'($urandom);
        endcase
        aluop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
        rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095)) & ~32'(sel == 3 && $urandom_range(0, 1) == 0);
    endtask

    task automatic test_reset();
        #3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (komut !== 32'h0) begin miscompares++; $display("FAIL reset_komut: got %h want 00000000", komut); end
        if (hata !== 1'b0) begin miscompares++; $display("FAIL reset_hata: got %b want 0", hata); end
        if (seviye !== '0) begin miscompares++; $display("FAIL reset_seviye: got %0d want 0", seviye); end
        if (hata_sayisi !== 8'd0) begin miscompares++; $display("FAIL reset_hata_sayisi: got %0d want 0", hata_sayisi); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors += 6;
        do_reset();
    endtask

    task automatic test_hatali();
        bit acc;
        logic [7:0] exp_cnt;
        do_reset();
        opcode = 7'b0000101; aluop = '0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; imm = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            if (hata !== 1'b1) begin miscompares++; $display("FAIL bad_opcode_hata[%0d]: got %b want 1", i, hata); end
            vectors++;
        end
        in_valid = 1'b0;
        tick(acc);
        exp_cnt = SAYAC ? 8'd3 : 8'd0;
        if (hata !== 1'b0) begin miscompares++; $display("FAIL bad_opcode_hata_end: got %b want 0", hata); end
        if (seviye !== '0) begin miscompares++; $display("FAIL bad_opcode_seviye: got %0d want 0", seviye); end
        if (hata_sayisi !== exp_cnt) begin miscompares++; $display("FAIL bad_opcode_count: got %0d want %0d", hata_sayisi, exp_cnt); end
        vectors += 3;
    endtask

    task automatic test_ornekler();
        logic [6:0]  t_op [5] = '{7'b0000001, 7'b0000011, 7'b0000111, 7'b0001111, 7'b0001111};
        logic [3:0]  t_alu[5] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [4:0]  t_r1 [5] = '{5'd1, 5'd6, 5'd0, 5'd2, 5'd2};
        logic [4:0]  t_r2 [5] = '{5'd2, 5'd0, 5'd0, 5'd3, 5'd3};
        logic [4:0]  t_rd [5] = '{5'd3, 5'd5, 5'd1, 5'd0, 5'd0};
        logic [31:0] t_imm[5] = '{32'h0, 32'h7FF, 32'hABCDE, 32'h24, 32'h25};
        logic [31:0] t_exp[5] = '{32'h40208181, 32'h7FF31283, 32'hABCDE087, 32'h0031090F, 32'h0};
        bit          t_bad[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit acc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            opcode = t_op[i]; aluop = t_alu[i]; rs1 = t_r1[i]; rs2 = t_r2[i]; rd = t_rd[i]; imm = t_imm[i];
            in_valid = 1'b1; out_ready = 1'b0;
            tick(acc);
            in_valid = 1'b0;
            if (!t_bad[i]) begin
                if (out_valid !== 1'b1) begin miscompares++; $display("FAIL example%0d_latency: out_valid %b want 1", i, out_valid); end
                if (komut !== t_exp[i]) begin miscompares++; $display("FAIL example%0d_komut: got %h want %h", i, komut, t_exp[i]); end
                if (hata !== 1'b0) begin miscompares++; $display("FAIL example%0d_hata: got %b want 0", i, hata); end
                tick(acc);
                if (komut !== t_exp[i]) begin miscompares++; $display("FAIL example%0d_hold: got %h want %h", i, komut, t_exp[i]); end
                out_ready = 1'b1;
                tick(acc);
                if (out_valid !== 1'b0) begin miscompares++; $display("FAIL example%0d_drain: out_valid %b want 0", i, out_valid); end
                if (komut !== t_exp[i]) begin miscompares++; $display("FAIL example%0d_empty_hold: got %h want %h", i, komut, t_exp[i]); end
                vectors += 6;
            end else begin
                if (hata !== 1'b1) begin miscompares++; $display("FAIL example%0d_reject: hata %b want 1", i, hata); end
                if (seviye !== '0) begin miscompares++; $display("FAIL example%0d_not_written: seviye %0d want 0", i, seviye); end
                tick(acc);
                if (hata !== 1'b0) begin miscompares++; $display("FAIL example%0d_pulse_width: hata %b want 0", i, hata); end
                vectors += 3;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_dolu();
        logic [31:0] beklenen[6];
        int k = 0;
        int p = 0;
        bit acc, pop_now;
        do_reset();
        for (int i = 0; i < 6; i++)
            void'(ref_enc(7'b0000001, 4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 32'h0, beklenen[i]));
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            opcode = 7'b0000001; aluop = 4'(k); rs1 = 5'(k + 1); rs2 = 5'(k + 2); rd = 5'(k + 3); imm = '0;
            tick(acc);
            if (acc) k++;
        end
        if (k !== 4) begin miscompares++; $display("FAIL full_accepted: got %0d want 4", k); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        if (seviye !== SW'(4)) begin miscompares++; $display("FAIL full_seviye: got %0d want 4", seviye); end
        vectors += 3;
        out_ready = 1'b1;
        if (komut !== beklenen[0]) begin miscompares++; $display("FAIL full_head: got %h want %h", komut, beklenen[0]); end
        tick(acc);
        p = 1;
        if (acc) k++;
        if (seviye !== SW'(3)) begin miscompares++; $display("FAIL no_push_through: seviye %0d want 3", seviye); end
        vectors += 2;
        for (int c = 0; c < 40 && p < 6; c++) begin
            if (k < 6) begin
                in_valid = 1'b1; opcode = 7'b0000001; aluop = 4'(k); rs1 = 5'(k + 1); rs2 = 5'(k + 2); rd = 5'(k + 3);
            end else begin
                in_valid = 1'b0;
            end
            pop_now = (q_m.size() != 0);
            if (pop_now) begin
                if (komut !== beklenen[p]) begin miscompares++; $display("FAIL drain_order[%0d]: got %h want %h", p, komut, beklenen[p]); end
                vectors++;
            end
            tick(acc);
            if (pop_now) p++;
            if (acc) k++;
        end
        if (p !== 6 || k !== 6) begin miscompares++; $display("FAIL drain_complete: popped %0d accepted %0d want 6 6", p, k); end
        vectors++;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_rastgele();
        bit acc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_tuple();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 5);
            tick(acc);
            if (in_ready !== (q_m.size() != D)) begin miscompares++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, q_m.size() != D); end
            if (out_valid !== (q_m.size() != 0)) begin miscompares++; $display("FAIL rnd_out_valid@%0d: got %b want %b", c, out_valid, q_m.size() != 0); end
            if (komut !== head_m) begin miscompares++; $display("FAIL rnd_komut@%0d: got %h want %h", c, komut, head_m); end
            if (seviye !== SW'(q_m.size())) begin miscompares++; $display("FAIL rnd_seviye@%0d: got %0d want %0d", c, seviye, q_m.size()); end
            if (hata !== hata_m) begin miscompares++; $display("FAIL rnd_hata@%0d: got %b want %b", c, hata, hata_m); end
            if (hata_sayisi !== 8'(cnt_m)) begin miscompares++; $display("FAIL rnd_hata_sayisi@%0d: got %0d want %0d", c, hata_sayisi, cnt_m); end
            vectors += 6;
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bit acc;
        logic [31:0] w;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = 7'b0000001; aluop = 4'(i + 2); rs1 = 5'(i); rs2 = 5'(i + 7); rd = 5'(i + 9); imm = '0;
            tick(acc);
        end
        in_valid = 1'b0;
        if (seviye !== SW'(3)) begin miscompares++; $display("FAIL areset_pre_seviye: got %0d want 3", seviye); end
        #2;
        rst_n = 1'b0;
        #1;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
        if (seviye !== '0) begin miscompares++; $display("FAIL areset_seviye: got %0d want 0", seviye); end
        if (komut !== 32'h0) begin miscompares++; $display("FAIL areset_komut: got %h want 00000000", komut); end
        vectors += 4;
        q_m.delete(); cnt_m = 0; head_m = '0; hata_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
        opcode = 7'b0000111; rd = 5'd4; imm = 32'h12345; in_valid = 1'b1;
        void'(ref_enc(opcode, aluop, rs1, rs2, rd, imm, w));
        tick(acc);
        in_valid = 1'b0;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_latency: out_valid %b want 1", out_valid); end
        if (komut !== w) begin miscompares++; $display("FAIL areset_komut_after: got %h want %h", komut, w); end
        if (seviye !== SW'(1)) begin miscompares++; $display("FAIL areset_seviye_after: got %0d want 1", seviye); end
        vectors += 4;
    endtask

    initial begin
        test_reset();
        test_hatali();
        test_ornekler();
        test_dolu();
        test_rastgele();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/komut_kodlayici.md
KOMUT_KODLAYICI -- requirements
Module: komut_kodlayici

Interface
REQ-001 Parameter: DERINLIK, default 4, output FIFO depth in words; power of two, at least 2.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1: field tuple valid.
REQ-005 Port in_ready, output, 1: block can accept a tuple.
REQ-006 Port opcode, input, 7: instruction class.
REQ-007 Port aluop, input, 4: ALU operation.
REQ-008 Ports rs1, rs2, rd, input, 5 each: register fields.
REQ-009 Port imm, input, 32: unencoded immediate.
REQ-010 Port out_valid, output, 1: head word valid.
REQ-011 Port out_ready, input, 1: consumer takes head word.
REQ-012 Port komut, output, 32: encoded instruction at FIFO head.
REQ-013 Port hata, output, 1: one-cycle pulse on rejected tuple.
REQ-014 Port seviye, output, $clog2(DERINLIK)+1: FIFO occupancy.
REQ-015 Port hata_sayisi, output, 8: rejected-tuple count.

Function
REQ-016 The block shall accept a tuple only when in_valid and in_ready are both 1; in_ready shall equal (seviye != DERINLIK).
REQ-017 Encoding shall be opcode in komut[6:0]; unlisted bits 0.
- R (0000001): rd[11:7], aluop[2:0][14:12], rs1[19:15], rs2[24:20], aluop[3][30].
- I (0000011): rd[11:7], aluop[2:0][14:12], rs1[19:15], imm[11:0][31:20].
- U (0000111): rd[11:7], imm[19:0][31:12].
- B (0001111): aluop[2:0][14:12], rs1[19:15], rs2[24:20], imm[5:1][11:7], imm[12:6][31:25].
REQ-018 An accepted tuple shall be rejected, and not written, on any of these conditions:
- any other opcode;
- I with imm[31:12] nonzero or aluop[3]=1;
- U with imm[31:20] nonzero;
- B with imm[0]=1, imm[31:13] nonzero, or aluop[3]=1.
REQ-019 On rejection, hata shall be 1 for exactly the cycle after acceptance; otherwise hata shall be 0.
REQ-020 A valid tuple accepted at edge N shall be visible at komut with out_valid=1 after edge N when the FIFO was empty (one-cycle latency).
REQ-021 A word shall leave the FIFO when out_valid and out_ready are both 1; komut shall hold stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop shall leave seviye unchanged; ordering shall be strict FIFO; pointers shall wrap modulo DERINLIK.
REQ-023 When the FIFO is full, in_ready shall be 0 even if out_ready=1 in the same cycle (no push-through).
REQ-024 When the FIFO is empty, out_valid shall be 0, komut shall hold its last value, and out_ready shall be ignored.

Reset
REQ-025 rst_n=0 shall asynchronously force out_valid=0, komut=0, hata=0, seviye=0, hata_sayisi=0, and pointers to 0.
REQ-026 Reset mid-operation shall discard all stored words; in_ready shall be 1 from the first edge after rst_n rises.

Configuration
REQ-027 Macro KOMUT_HATA_SAYACI_EN: when defined, hata_sayisi shall increment by 1 on each rejection and saturate at 255.
REQ-028 When KOMUT_HATA_SAYACI_EN is undefined, hata_sayisi shall be constant 0 and no counter register shall exist; the port shall remain.

Structure
REQ-029 Package komut_pkg shall hold the opcode constants R, I, U, B, the komut_alanlari_t struct (opcode, aluop, rs1, rs2, rd, imm), and the field bit-position constants.
REQ-030 The storage shall be sub-module komut_fifo (parameter DERINLIK, 32-bit data, push/pop/seviye); encode and check logic shall reside in komut_kodlayici.

Verification
REQ-031 R: opcode=0000001, rd=3, rs1=1, rs2=2, aluop=1000 -> komut=0x40208181, out_valid one cycle after accept.
REQ-032 I: opcode=0000011, rd=5, rs1=6, aluop=0001, imm=0x7FF -> 0x7FF31283; U: opcode=0000111, rd=1, imm=0xABCDE -> 0xABCDE087.
REQ-033 B: opcode=0001111, rs1=2, rs2=3, aluop=0, imm=0x24 -> 0x0031090F; same with imm=0x25 -> hata pulse, nothing written.
REQ-034 Opcode 0000101 sent three times -> three hata pulses, seviye=0, hata_sayisi=3 (0 with the macro undefined).
REQ-035 DERINLIK=4, out_ready=0, six valid tuples offered -> four accepted, in_ready=0, seviye=4; out_ready=1 -> words drain in order, remaining two accepted.
REQ-036 rst_n pulled low with seviye=3 -> out_valid=0 and seviye=0 immediately (asynchronously); the next tuple has one-cycle latency.
